// File: rtl/cpu_state_dumper.sv
// Streams the CPU register file followed by a window of data memory over a
// valid/ready port, one word per cycle, for end-of-run state inspection.
module cpu_state_dumper #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DM_AW    = 6,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DM_AW-1:0]  dm_base,
  input  logic [DM_AW:0]    dm_count,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DM_AW-1:0]  dm_raddr,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic [DM_AW:0]    out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned OI_W  = DM_AW + 1;
  localparam int unsigned IDX_W = (OI_W > 5) ? OI_W : 5;

  typedef enum logic [1:0] {IDLE, REGS, MEM, DRAIN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [DM_AW-1:0]   base_q;
  logic [DM_AW:0]     count_q;
  logic [IDX_W-1:0]   last_mem_idx;
  logic               load_ok;

  assign load_ok      = !out_valid || out_ready;
  assign last_mem_idx = IDX_W'(count_q) - IDX_W'(1);

  // Register 0 is loaded on the accepting edge itself, so the read port must
  // already point at it while idle.
  assign rf_raddr = (state == IDLE) ? 5'd0 : idx[4:0];
  assign dm_raddr = base_q + idx[DM_AW-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      base_q    <= '0;
      count_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q    <= dm_base;
            count_q   <= dm_count;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= rf_rdata;
            out_src   <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
            idx       <= IDX_W'(1);
            state     <= REGS;
          end
        end
        REGS: begin
          if (load_ok) begin
            out_valid <= 1'b1;
            out_data  <= rf_rdata;
            out_src   <= 1'b0;
            out_index <= OI_W'(idx);
            if (idx == IDX_W'(NUM_REGS - 1)) begin
              idx <= '0;
              if (count_q == '0) begin
                out_last <= 1'b1;
                state    <= DRAIN;
              end else begin
                state <= MEM;
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        MEM: begin
          if (load_ok) begin
            out_valid <= 1'b1;
            out_data  <= dm_rdata;
            out_src   <= 1'b1;
            out_index <= {1'b0, dm_raddr};
            if (idx == last_mem_idx) begin
              out_last <= 1'b1;
              state    <= DRAIN;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            idx       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
